// File: rtl/ap_pass_sequencer.sv
// ap_pass_sequencer: bit-serial ADD/SUB microsequencer broadcasting compare/write passes to a CAM row array
//   clka, rst       clock, synchronous active-high reset
//   start, op       launch request (IDLE only) and operation (0 ADD, 1 SUB)
//   hold            freezes sequencing and suppresses strobes
//   busy, done      run in progress, one-cycle completion pulse
//   cam_key/mask/din compare key, compare-or-write mask, write data
//   tag_en, cam_we  tag capture strobe, masked write strobe for tagged rows
module ap_pass_sequencer #(
  parameter int OP_BITS = 4
) (
  input  logic                 clka,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 op,
  input  logic                 hold,
  output logic                 busy,
  output logic                 done,
  output logic [2*OP_BITS:0]   cam_key,
  output logic [2*OP_BITS:0]   cam_mask,
  output logic [2*OP_BITS:0]   cam_din,
  output logic                 tag_en,
  output logic                 cam_we
);
  localparam int W = 2*OP_BITS+1;
  localparam int BW = OP_BITS > 1 ? $clog2(OP_BITS) : 1;
  localparam logic [BW-1:0] LAST = BW'(OP_BITS-1);
  // pass tables: key is {C,B,A}, new value is {C',B'}; order keeps rewritten rows from re-matching
  localparam logic [2:0] ADD_KEY [4] = '{3'b011, 3'b001, 3'b100, 3'b110};
  localparam logic [1:0] ADD_NEW [4] = '{2'b10, 2'b01, 2'b01, 2'b10};
  localparam logic [2:0] SUB_KEY [4] = '{3'b001, 3'b011, 3'b110, 3'b100};
  localparam logic [1:0] SUB_NEW [4] = '{2'b11, 2'b00, 2'b00, 2'b11};
  typedef enum logic [2:0] {S_IDLE, S_CLR_CMP, S_CLR_WR, S_CMP, S_WR, S_DONE} state_t;
  state_t        r_state, w_next;
  logic [BW-1:0] r_bit;
  logic [1:0]    r_pass;
  logic          r_op;
  logic [W-1:0]  w_cpos, w_bpos, w_apos;
  logic [2:0]    w_pat;
  logic [1:0]    w_new;
  always_ff @(posedge clka) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_bit   <= '0;
      r_pass  <= '0;
      r_op    <= 1'b0;
    end else if (!hold) begin
      r_state <= w_next;
      if (r_state == S_IDLE && start) r_op <= op;
      if (r_state == S_CLR_WR) begin
        r_bit  <= '0;
        r_pass <= '0;
      end else if (r_state == S_WR) begin
        r_pass <= r_pass + 2'd1;
        if (r_pass == 2'd3 && r_bit != LAST) r_bit <= r_bit + 1'b1;
      end
    end
  end
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:    w_next = start ? S_CLR_CMP : S_IDLE;
      S_CLR_CMP: w_next = S_CLR_WR;
      S_CLR_WR:  w_next = S_CMP;
      S_CMP:     w_next = S_WR;
      S_WR:      w_next = (r_pass == 2'd3 && r_bit == LAST) ? S_DONE : S_CMP;
      default:   w_next = S_IDLE;
    endcase
  end
  always_comb begin
    w_cpos   = W'(1) << (2*OP_BITS);
    w_bpos   = W'(1) << (OP_BITS + int'(r_bit));
    w_apos   = W'(1) << r_bit;
    w_pat    = r_op ? SUB_KEY[r_pass] : ADD_KEY[r_pass];
    w_new    = r_op ? SUB_NEW[r_pass] : ADD_NEW[r_pass];
    cam_mask = r_state == S_CLR_WR ? w_cpos :
               r_state == S_CMP    ? w_cpos | w_bpos | w_apos :
               r_state == S_WR     ? w_cpos | w_bpos : '0;
    cam_key  = r_state == S_CMP ? (w_pat[2] ? w_cpos : '0) | (w_pat[1] ? w_bpos : '0) | (w_pat[0] ? w_apos : '0) : '0;
    cam_din  = r_state == S_WR ? (w_new[1] ? w_cpos : '0) | (w_new[0] ? w_bpos : '0) : '0;
    tag_en   = (r_state == S_CLR_CMP || r_state == S_CMP) && !hold;
    cam_we   = (r_state == S_CLR_WR || r_state == S_WR) && !hold;
    busy     = r_state != S_IDLE;
    done     = r_state == S_DONE;
  end
endmodule

// File: tb/tb_ap_pass_sequencer.sv
// tb_ap_pass_sequencer: directed bench with a 4-row CAM model driven by the sequencer
module tb_ap_pass_sequencer;
  logic clka = 1'b0;
  logic rst = 1'b1, start = 1'b0, op = 1'b0, hold = 1'b0;
  logic busy, done, tag_en, cam_we;
  logic [8:0] cam_key, cam_mask, cam_din;
  int checks = 0, failures = 0;
  logic [8:0] mem [4];
  logic tag [4];
  logic ld = 1'b0;
  logic [8:0] ld_rows [4];
  logic tr_tag [5], tr_we [5], tr_busy [5];
  logic [8:0] tr_mask [5], tr_key [5], tr_din [5];
  ap_pass_sequencer #(.OP_BITS(4)) dut (
    .clka(clka), .rst(rst), .start(start), .op(op), .hold(hold),
    .busy(busy), .done(done), .cam_key(cam_key), .cam_mask(cam_mask),
    .cam_din(cam_din), .tag_en(tag_en), .cam_we(cam_we)
  );
  always #5 clka = ~clka;
  always @(posedge clka)
    for (int r = 0; r < 4; r++) begin
      if (ld) mem[r] <= ld_rows[r];
      else if (cam_we && tag[r] === 1'b1) mem[r] <= (mem[r] & ~cam_mask) | (cam_din & cam_mask);
      if (tag_en) tag[r] <= ((mem[r] ^ cam_key) & cam_mask) == 9'h0;
    end
  task automatic load(input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2, input logic [7:0] r3);
    @(negedge clka);
    ld_rows[0] = {1'b1, r0};
    ld_rows[1] = {1'b1, r1};
    ld_rows[2] = {1'b1, r2};
    ld_rows[3] = {1'b1, r3};
    ld = 1'b1;
    @(negedge clka);
    ld = 1'b0;
  endtask
  task automatic run(input logic op_v, input int hold_at, input int rst_at, input bit spam, output int n);
    logic [8:0] pm;
    logic ph;
    pm = '0;
    ph = 1'b0;
    @(negedge clka);
    op = op_v;
    start = 1'b1;
    n = 0;
    while (n < 200) begin
      @(negedge clka);
      n++;
      checks++;
      if (tag_en && cam_we) begin
        failures++;
        $display("FAIL strobe_overlap cycle %0d: tag_en=%b cam_we=%b, required not both high", n, tag_en, cam_we);
      end
      if (hold) begin
        checks++;
        if (tag_en || cam_we || (ph && cam_mask !== pm)) begin
          failures++;
          $display("FAIL hold_freeze cycle %0d: tag_en=%b cam_we=%b mask=%h prev=%h, required strobes 0 and mask stable", n, tag_en, cam_we, cam_mask, pm);
        end
      end
      if (n <= 4) begin
        tr_tag[n] = tag_en; tr_we[n] = cam_we; tr_busy[n] = busy;
        tr_mask[n] = cam_mask; tr_key[n] = cam_key; tr_din[n] = cam_din;
      end
      if (done) break;
      if (n == rst_at) begin
        rst = 1'b1;
        break;
      end
      ph = hold;
      pm = cam_mask;
      hold = n >= hold_at && n < hold_at + 5;
      start = spam && (n % 3 == 0);
      op = spam ? ~op_v : op_v;
    end
    start = 1'b0;
    hold = 1'b0;
    op = op_v;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clka);
    checks++;
    if ({busy, done, tag_en, cam_we, cam_key, cam_mask, cam_din} !== 31'h0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b done=%b tag_en=%b we=%b key=%h mask=%h din=%h, required all 0", busy, done, tag_en, cam_we, cam_key, cam_mask, cam_din);
    end
    rst = 1'b0;
  endtask
  task automatic test_add;
    int n;
    logic [8:0] exp [4] = '{9'h083, 9'h10F, 9'h000, 9'h129};
    load(8'h53, 8'h1F, 8'h00, 8'h99);
    run(1'b0, 1000, 1000, 1'b0, n);
    checks++;
    if (n !== 35) begin failures++; $display("FAIL add_latency: done at cycle %0d, required 35", n); end
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (mem[r] !== exp[r]) begin failures++; $display("FAIL add_row%0d: {C,B,A}=%h, required %h", r, mem[r], exp[r]); end
    end
    checks++;
    if ({tr_busy[1], tr_tag[1], tr_we[1], tr_mask[1]} !== {3'b110, 9'h000}) begin
      failures++; $display("FAIL trace_c1: busy=%b tag=%b we=%b mask=%h, required 1 1 0 000", tr_busy[1], tr_tag[1], tr_we[1], tr_mask[1]);
    end
    checks++;
    if ({tr_tag[2], tr_we[2], tr_mask[2], tr_din[2]} !== {2'b01, 9'h100, 9'h000}) begin
      failures++; $display("FAIL trace_c2: tag=%b we=%b mask=%h din=%h, required 0 1 100 000", tr_tag[2], tr_we[2], tr_mask[2], tr_din[2]);
    end
    checks++;
    if ({tr_tag[3], tr_we[3], tr_mask[3], tr_key[3]} !== {2'b10, 9'h111, 9'h011}) begin
      failures++; $display("FAIL trace_c3: tag=%b we=%b mask=%h key=%h, required 1 0 111 011", tr_tag[3], tr_we[3], tr_mask[3], tr_key[3]);
    end
    checks++;
    if ({tr_tag[4], tr_we[4], tr_mask[4], tr_din[4]} !== {2'b01, 9'h110, 9'h100}) begin
      failures++; $display("FAIL trace_c4: tag=%b we=%b mask=%h din=%h, required 0 1 110 100", tr_tag[4], tr_we[4], tr_mask[4], tr_din[4]);
    end
    @(negedge clka);
    checks++;
    if ({busy, done} !== 2'b00) begin failures++; $display("FAIL add_idle_after: busy=%b done=%b, required 0 0", busy, done); end
  endtask
  task automatic test_sub;
    int n;
    logic [8:0] exp [4] = '{9'h023, 9'h1E5, 9'h000, 9'h00F};
    load(8'h53, 8'h35, 8'h00, 8'hFF);
    run(1'b1, 1000, 1000, 1'b0, n);
    checks++;
    if (n !== 35) begin failures++; $display("FAIL sub_latency: done at cycle %0d, required 35", n); end
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (mem[r] !== exp[r]) begin failures++; $display("FAIL sub_row%0d: {C,B,A}=%h, required %h", r, mem[r], exp[r]); end
    end
  endtask
  task automatic test_interference;
    int n;
    logic [8:0] exp [4] = '{9'h083, 9'h10F, 9'h000, 9'h129};
    load(8'h53, 8'h1F, 8'h00, 8'h99);
    run(1'b0, 10, 1000, 1'b1, n);
    checks++;
    if (n !== 40) begin failures++; $display("FAIL hold_latency: done at cycle %0d, required 40", n); end
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (mem[r] !== exp[r]) begin failures++; $display("FAIL interf_row%0d: {C,B,A}=%h, required %h", r, mem[r], exp[r]); end
    end
  endtask
  task automatic test_reset_mid;
    int n;
    logic [8:0] exp [4] = '{9'h023, 9'h1E5, 9'h000, 9'h00F};
    load(8'h53, 8'h1F, 8'h00, 8'h99);
    run(1'b0, 1000, 10, 1'b0, n);
    @(negedge clka);
    checks++;
    if ({busy, done, tag_en, cam_we, cam_key, cam_mask, cam_din} !== 31'h0) begin
      failures++;
      $display("FAIL midrun_reset: busy=%b done=%b tag_en=%b we=%b key=%h mask=%h din=%h, required all 0", busy, done, tag_en, cam_we, cam_key, cam_mask, cam_din);
    end
    rst = 1'b0;
    load(8'h53, 8'h35, 8'h00, 8'hFF);
    run(1'b1, 1000, 1000, 1'b0, n);
    checks++;
    if (n !== 35) begin failures++; $display("FAIL rerun_latency: done at cycle %0d, required 35", n); end
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (mem[r] !== exp[r]) begin failures++; $display("FAIL rerun_row%0d: {C,B,A}=%h, required %h", r, mem[r], exp[r]); end
    end
  endtask
  initial begin
    test_reset;
    test_add;
    test_sub;
    test_interference;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ap_pass_sequencer.md
Name: ap_pass_sequencer

Overview:
- Microsequencer that runs bit-serial in-place ADD or SUB over a CAM row array.
- Broadcasts compare/write passes to every row. Each pass is one compare cycle (rows latch match into a per-row tag) followed by one write cycle (tagged rows take a masked write).
- Sits between the AP instruction front-end and the CAM array.
- Row word layout: A in bits [OP_BITS-1:0], B in bits [2*OP_BITS-1:OP_BITS], carry/borrow C in bit 2*OP_BITS. The result overwrites B.

Parameters:
- OP_BITS, default 4: operand width in bits. Derived localparam W = 2*OP_BITS+1 is the CAM word width.

Ports:
- clka  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  launch request; sampled only in IDLE.
- op  in  1  0 = ADD (B <= B+A), 1 = SUB (B <= B-A); captured with start.
- hold  in  1  freezes sequencing while high (array busy with host access).
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- done  out  1  one-cycle pulse at completion.
- cam_key  out  W  compare key, broadcast to all rows.
- cam_mask  out  W  compare mask in CMP states; write mask in WR states.
- cam_din  out  W  write data.
- tag_en  out  1  rows capture match into their tag at this edge.
- cam_we  out  1  rows with tag=1 perform masked write.

Behaviour:
- States: IDLE, CLR_CMP, CLR_WR, CMP, WR, DONE.
- State, bit counter bit_idx (0..OP_BITS-1) and pass counter pass_idx (0..3) are registered.
- cam_key, cam_mask and cam_din are pure decodes of the registered state.
- tag_en = (state in {CLR_CMP, CMP}) & ~hold.
- cam_we = (state in {CLR_WR, WR}) & ~hold.
- Reset (any state, mid-operation included): next edge goes to IDLE and clears the counters. All outputs are 0. No further strobes are issued. Array contents are not restored.
- IDLE: all outputs 0. start=1 latches op and goes to CLR_CMP. start in any other state is ignored.
- CLR_CMP: mask=0, so every row matches. Next state CLR_WR.
- CLR_WR: mask=1<<2*OP_BITS, din=0, which clears C in all rows. Next state CMP with bit_idx=0, pass_idx=0.
- CMP: mask = C | B[i] | A[i] bit positions, where i = bit_idx. Key = pattern from the op table, entry pass_idx, placed at those bits. Next state WR.
- WR: mask = C | B[i] bit positions; din = new (C,B) values from the table.
  - If pass_idx<3: increment pass_idx, go to CMP.
  - Else if bit_idx<OP_BITS-1: clear pass_idx, increment bit_idx, go to CMP.
  - Else go to DONE.
- DONE: done=1, busy=1, then IDLE.
- ADD table, (C,B,A) -> (C',B'), in this order: (0,1,1)->(1,0); (0,0,1)->(0,1); (1,0,0)->(0,1); (1,1,0)->(1,0).
- SUB table, (C,B,A) -> (C',B'), in this order: (0,0,1)->(1,1); (0,1,1)->(0,0); (1,1,0)->(0,0); (1,0,0)->(1,1).
- Pass order is fixed. No row rewritten by a pass may match a later pass of the same bit.
- Latency:
  - One CMP+WR pair takes 2 cycles; the clear pass takes 2 cycles.
  - Total = 2 + 8*OP_BITS, plus 1 DONE cycle; 35 cycles for OP_BITS=4.
  - start at edge 0 gives done high in cycle 35.
- hold:
  - State and counters freeze.
  - key/mask/din stay stable.
  - Strobes are forced to 0 and re-issue once hold deasserts.
  - Completion is delayed exactly by the number of held cycles.
- Final C holds carry-out (ADD) or borrow-out (SUB). B wraps modulo 2^OP_BITS.

Test Plan:
- Bench: 4-row CAM array model with per-row tag registers; OP_BITS=4.
- ADD, rows (A,B)=(3,5),(15,1),(0,0),(9,9) -> B=8,C=0; B=0,C=1; B=0,C=0; B=2,C=1. A unchanged. done exactly 35 cycles after start.
- SUB, rows (A,B)=(3,5),(5,3),(0,0),(15,15) -> B=2,C=0; B=14,C=1; B=0,C=0; B=0,C=0.
- ADD strobe trace:
  - cycle1: tag_en, mask=0x000.
  - cycle2: cam_we, mask=0x100, din=0.
  - cycle3: tag_en, mask=0x111, key=0x011.
  - cycle4: cam_we, mask=0x110, din=0x100.
  - Never tag_en and cam_we high together.
- Interference: start pulses during busy are ignored. hold high for 5 cycles mid-run -> no strobes while held, done at cycle 40, results identical to the unheld run.
- rst at cycle 10 of ADD -> next cycle all outputs 0 and busy=0. A fresh start runs a full 35-cycle sequence with correct results on reloaded rows.
